// File: rtl/jvm_pkg.sv
// Shared JVM bytecode definitions.
// Holds the opcode constants, the decode state encoding and the default
// program-counter width. The decode stage and the length lookup both use
// this package.
package jvm_pkg;

   localparam int PC_W_DEF = 12;

   typedef enum logic [1:0] {
      ST_OPC = 2'd0,
      ST_OP1 = 2'd1,
      ST_OP2 = 2'd2
   } dec_state_t;

   localparam logic [7:0] OP_NOP       = 8'h00;
   localparam logic [7:0] OP_ICONST_M1 = 8'h02;
   localparam logic [7:0] OP_ICONST_5  = 8'h08;
   localparam logic [7:0] OP_BIPUSH    = 8'h10;
   localparam logic [7:0] OP_SIPUSH    = 8'h11;
   localparam logic [7:0] OP_ILOAD     = 8'h15;
   localparam logic [7:0] OP_ILOAD_0   = 8'h1A;
   localparam logic [7:0] OP_ILOAD_3   = 8'h1D;
   localparam logic [7:0] OP_ISTORE    = 8'h36;
   localparam logic [7:0] OP_ISTORE_0  = 8'h3B;
   localparam logic [7:0] OP_ISTORE_3  = 8'h3E;
   localparam logic [7:0] OP_POP       = 8'h57;
   localparam logic [7:0] OP_DUP       = 8'h59;
   localparam logic [7:0] OP_IADD      = 8'h60;
   localparam logic [7:0] OP_ISUB      = 8'h64;
   localparam logic [7:0] OP_IMUL      = 8'h68;
   localparam logic [7:0] OP_IINC      = 8'h84;
   localparam logic [7:0] OP_IFEQ      = 8'h99;
   localparam logic [7:0] OP_IF_ICMPLE = 8'hA4;
   localparam logic [7:0] OP_GOTO      = 8'hA7;
   localparam logic [7:0] OP_IRETURN   = 8'hAC;
   localparam logic [7:0] OP_RETURN    = 8'hB1;

   // Operand for 2-byte instructions. bipush carries a signed immediate;
   // iload/istore carry an unsigned local-variable index.
   function automatic logic [15:0] short_operand(input logic [7:0] op,
                                                 input logic [7:0] b1);
      return (op == OP_BIPUSH) ? {{8{b1[7]}}, b1} : {8'h00, b1};
   endfunction

endpackage

// File: rtl/bytecode_len.sv
// Combinational bytecode length lookup.
// Ports:
//   opcode  - bytecode opcode byte
//   len     - total instruction length in bytes (1..3)
//   illegal - opcode is outside the supported set (reported as length 1)
module bytecode_len
   import jvm_pkg::*;
(
   input  logic [7:0] opcode,
   output logic [1:0] len,
   output logic       illegal
);

   always_comb begin
      len     = 2'd1;
      illegal = 1'b0;
      case (opcode) inside
         OP_BIPUSH, OP_ILOAD, OP_ISTORE:                        len = 2'd2;
         OP_SIPUSH, OP_IINC, [OP_IFEQ:OP_IF_ICMPLE], OP_GOTO:   len = 2'd3;
         OP_NOP, [OP_ICONST_M1:OP_ICONST_5], [OP_ILOAD_0:OP_ILOAD_3],
         [OP_ISTORE_0:OP_ISTORE_3], OP_POP, OP_DUP, OP_IADD, OP_ISUB,
         OP_IMUL, OP_IRETURN, OP_RETURN:                        len = 2'd1;
         default:                                               illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/bytecode_decode.sv
// Bytecode decode stage.
// Collects the opcode and operand bytes of each bytecode from the fetch
// byte stream and presents one assembled record per instruction to execute.
//
//   state  | meaning
//   -------+-------------------------------------------
//   ST_OPC | waiting for an opcode byte
//   ST_OP1 | opcode latched, waiting for operand byte 1
//   ST_OP2 | operand byte 1 latched, waiting for byte 2
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_byte/in_pc/in_valid   - byte stream from fetch
//   in_ready                 - byte accepted this cycle
//   flush                    - discard partial instruction and pending record
//   dec_valid/dec_ready      - record handshake to execute
//   dec_opcode/dec_operand   - opcode and assembled operand
//   dec_pc/dec_len           - opcode pc and instruction length
//   dec_illegal              - opcode not supported
module bytecode_decode
   import jvm_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      in_byte,
   input  logic [PC_W-1:0] in_pc,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            flush,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [7:0]      dec_opcode,
   output logic [15:0]     dec_operand,
   output logic [PC_W-1:0] dec_pc,
   output logic [1:0]      dec_len,
   output logic            dec_illegal
);

   dec_state_t      state;
   logic [7:0]      lat_op;
   logic [7:0]      lat_b1;
   logic [PC_W-1:0] lat_pc;
   logic [1:0]      lat_len;

   logic [1:0]      opc_len;
   logic            opc_illegal;
   logic            take;

   bytecode_len u_len (
      .opcode  (in_byte),
      .len     (opc_len),
      .illegal (opc_illegal)
   );

   // A byte only moves when the output register is free or draining, so a
   // final operand byte can never overwrite an unconsumed record.
   assign in_ready = !dec_valid || dec_ready;
   assign take     = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_OPC;
         lat_op      <= '0;
         lat_b1      <= '0;
         lat_pc      <= '0;
         lat_len     <= '0;
         dec_valid   <= 1'b0;
         dec_opcode  <= '0;
         dec_operand <= '0;
         dec_pc      <= '0;
         dec_len     <= '0;
         dec_illegal <= 1'b0;
      end else if (flush) begin
         state     <= ST_OPC;
         dec_valid <= 1'b0;
      end else begin
         if (dec_valid && dec_ready)
            dec_valid <= 1'b0;
         if (take) begin
            case (state)
               ST_OPC: begin
                  if (opc_len == 2'd1) begin
                     dec_valid   <= 1'b1;
                     dec_opcode  <= in_byte;
                     dec_operand <= '0;
                     dec_pc      <= in_pc;
                     dec_len     <= 2'd1;
                     dec_illegal <= opc_illegal;
                  end else begin
                     lat_op  <= in_byte;
                     lat_pc  <= in_pc;
                     lat_len <= opc_len;
                     state   <= ST_OP1;
                  end
               end
               ST_OP1: begin
                  if (lat_len == 2'd2) begin
                     dec_valid   <= 1'b1;
                     dec_opcode  <= lat_op;
                     dec_operand <= short_operand(lat_op, in_byte);
                     dec_pc      <= lat_pc;
                     dec_len     <= 2'd2;
                     dec_illegal <= 1'b0;
                     state       <= ST_OPC;
                  end else begin
                     lat_b1 <= in_byte;
                     state  <= ST_OP2;
                  end
               end
               ST_OP2: begin
                  // Big-endian; branch offsets are left raw for execute.
                  dec_valid   <= 1'b1;
                  dec_opcode  <= lat_op;
                  dec_operand <= {lat_b1, in_byte};
                  dec_pc      <= lat_pc;
                  dec_len     <= 2'd3;
                  dec_illegal <= 1'b0;
                  state       <= ST_OPC;
               end
               default: state <= ST_OPC;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bytecode_decode.sv
module tb_bytecode_decode;

   localparam int PC_W = 12;

   logic            clk = 1'b0;
   logic            rst;
   logic [7:0]      in_byte;
   logic [PC_W-1:0] in_pc;
   logic            in_valid;
   logic            in_ready;
   logic            flush;
   logic            dec_valid;
   logic            dec_ready;
   logic [7:0]      dec_opcode;
   logic [15:0]     dec_operand;
   logic [PC_W-1:0] dec_pc;
   logic [1:0]      dec_len;
   logic            dec_illegal;

   int n_cmp = 0;
   int n_bad = 0;

   bytecode_decode #(.PC_W(PC_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_byte     (in_byte),
      .in_pc       (in_pc),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .flush       (flush),
      .dec_valid   (dec_valid),
      .dec_ready   (dec_ready),
      .dec_opcode  (dec_opcode),
      .dec_operand (dec_operand),
      .dec_pc      (dec_pc),
      .dec_len     (dec_len),
      .dec_illegal (dec_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end

   function automatic logic [63:0] pk(input logic [7:0] op, input logic [15:0] opd,
                                      input logic [1:0] len, input logic ill,
                                      input logic [11:0] pc);
      return {25'd0, op, opd, len, ill, pc};
   endfunction

   function automatic logic [63:0] dut_rec();
      return pk(dec_opcode, dec_operand, dec_len, dec_illegal, dec_pc);
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge; outputs are sampled 1 unit later.
   task automatic step(input logic v, input logic [7:0] b, input logic [11:0] pc,
                       input logic rdy, input logic fl, input logic r = 1'b0);
      @(negedge clk);
      in_valid  = v;
      in_byte   = b;
      in_pc     = pc;
      dec_ready = rdy;
      flush     = fl;
      rst       = r;
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic int ref_len(input logic [7:0] op);
      if (op == 8'h10 || op == 8'h15 || op == 8'h36) return 2;
      if (op == 8'h11 || op == 8'h84 || op == 8'hA7 || (op >= 8'h99 && op <= 8'hA4)) return 3;
      return 1;
   endfunction

   function automatic logic ref_legal(input logic [7:0] op);
      if (ref_len(op) > 1) return 1'b1;
      if (op == 8'h00 || (op >= 8'h02 && op <= 8'h08)) return 1'b1;
      if ((op >= 8'h1A && op <= 8'h1D) || (op >= 8'h3B && op <= 8'h3E)) return 1'b1;
      if (op == 8'h57 || op == 8'h59 || op == 8'h60 || op == 8'h64) return 1'b1;
      if (op == 8'h68 || op == 8'hAC || op == 8'hB1) return 1'b1;
      return 1'b0;
   endfunction

   logic [7:0]  pend_b[$];
   logic [11:0] pend_pc;
   logic [63:0] exp_q[$];

   task automatic model_push(input logic [7:0] b, input logic [11:0] pc);
      int l;
      int v;
      logic [15:0] opd;
      pend_b.push_back(b);
      if (pend_b.size() == 1) pend_pc = pc;
      l = ref_len(pend_b[0]);
      if (pend_b.size() == l) begin
         if (l == 1) opd = 16'd0;
         else if (l == 2) begin
            v = int'(pend_b[1]);
            if (pend_b[0] == 8'h10 && v > 127) v = v - 256;
            opd = 16'(v);
         end else opd = 16'(int'(pend_b[1]) * 256 + int'(pend_b[2]));
         exp_q.push_back(pk(pend_b[0], opd, 2'(l), !ref_legal(pend_b[0]), pend_pc));
         pend_b.delete();
      end
   endtask

   logic [7:0] legal_ops[16] = '{8'h00, 8'h04, 8'h10, 8'h11, 8'h15, 8'h1B, 8'h36, 8'h3D,
                                 8'h59, 8'h60, 8'h84, 8'h99, 8'h9F, 8'hA4, 8'hA7, 8'hB1};

   function automatic logic [7:0] pick();
      if ($urandom_range(0, 1) == 0) return legal_ops[$urandom_range(0, 15)];
      return 8'($urandom_range(0, 255));
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0]  b;
      logic        rec;
      logic [7:0]  op;
      logic [15:0] opd;
      logic [1:0]  len;
      logic        ill;
      logic [11:0] pc;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic [7:0] b, input logic rec, input logic [7:0] op,
                               input logic [15:0] opd, input logic [1:0] len,
                               input logic ill, input logic [11:0] pc);
      vec_t t;
      t.b = b; t.rec = rec; t.op = op; t.opd = opd; t.len = len; t.ill = ill; t.pc = pc;
      return t;
   endfunction

   logic        hold;
   logic        prev_stall;
   logic [63:0] prev_rec;
   logic [11:0] rpc;

   initial begin
      vecs[0]  = mk(8'h10, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(8'hFE, 1, 8'h10, 16'hFFFE, 2, 0, 0);
      vecs[2]  = mk(8'h60, 1, 8'h60, 16'h0000, 1, 0, 2);
      vecs[3]  = mk(8'h11, 0, 0, 0, 0, 0, 0);
      vecs[4]  = mk(8'h12, 0, 0, 0, 0, 0, 0);
      vecs[5]  = mk(8'h34, 1, 8'h11, 16'h1234, 3, 0, 3);
      vecs[6]  = mk(8'hA7, 0, 0, 0, 0, 0, 0);
      vecs[7]  = mk(8'hFF, 0, 0, 0, 0, 0, 0);
      vecs[8]  = mk(8'hFC, 1, 8'hA7, 16'hFFFC, 3, 0, 6);
      vecs[9]  = mk(8'hCA, 1, 8'hCA, 16'h0000, 1, 1, 9);
      vecs[10] = mk(8'h15, 0, 0, 0, 0, 0, 0);
      vecs[11] = mk(8'h07, 1, 8'h15, 16'h0007, 2, 0, 10);
      vecs[12] = mk(8'h36, 0, 0, 0, 0, 0, 0);
      vecs[13] = mk(8'h80, 1, 8'h36, 16'h0080, 2, 0, 12);
      vecs[14] = mk(8'h84, 0, 0, 0, 0, 0, 0);
      vecs[15] = mk(8'h03, 0, 0, 0, 0, 0, 0);
      vecs[16] = mk(8'hFF, 1, 8'h84, 16'h03FF, 3, 0, 14);
      vecs[17] = mk(8'h9F, 0, 0, 0, 0, 0, 0);
      vecs[18] = mk(8'h80, 0, 0, 0, 0, 0, 0);
      vecs[19] = mk(8'h00, 1, 8'h9F, 16'h8000, 3, 0, 17);
      vecs[20] = mk(8'h00, 1, 8'h00, 16'h0000, 1, 0, 20);
      vecs[21] = mk(8'h02, 1, 8'h02, 16'h0000, 1, 0, 21);
      vecs[22] = mk(8'hB1, 1, 8'hB1, 16'h0000, 1, 0, 22);
      vecs[23] = mk(8'h10, 0, 0, 0, 0, 0, 0);
      vecs[24] = mk(8'h7F, 1, 8'h10, 16'h007F, 2, 0, 23);

      rst = 1'b1; in_valid = 1'b0; in_byte = '0; in_pc = '0; flush = 1'b0; dec_ready = 1'b1;
      repeat (2) @(posedge clk);

      // Reset state
      step(0, 8'h00, 12'h000, 1, 0);
      check("reset_valid", dec_valid, 0);
      check("reset_outputs", dut_rec(), 0);
      check("reset_in_ready", in_ready, 1);

      // Table: one byte per cycle, record expected the cycle after its last byte
      for (int i = 0; i <= NV; i++) begin
         if (i < NV) step(1, vecs[i].b, 12'(i), 1, 0);
         else        step(0, 8'h00, 12'h000, 1, 0);
         if (i > 0) begin
            check("table_valid", dec_valid, vecs[i-1].rec);
            if (vecs[i-1].rec)
               check("table_rec", dut_rec(),
                     pk(vecs[i-1].op, vecs[i-1].opd, vecs[i-1].len, vecs[i-1].ill, vecs[i-1].pc));
         end
      end

      // Backpressure: 04 decoded, 05 held by fetch while dec_ready=0
      step(1, 8'h04, 12'h040, 1, 0);
      step(1, 8'h05, 12'h041, 0, 0);
      check("stall_valid", dec_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_rec", dut_rec(), pk(8'h04, 0, 1, 0, 12'h040));
      for (int k = 0; k < 3; k++) begin
         step(1, 8'h05, 12'h041, 0, 0);
         check("stall_hold_in_ready", in_ready, 0);
         check("stall_hold_rec", {dec_valid, dut_rec()}, {1'b1, pk(8'h04, 0, 1, 0, 12'h040)});
      end
      step(1, 8'h05, 12'h041, 1, 0);
      check("release_in_ready", in_ready, 1);
      check("release_rec04", dut_rec(), pk(8'h04, 0, 1, 0, 12'h040));
      step(0, 8'h00, 12'h000, 1, 0);
      check("release_valid05", dec_valid, 1);
      check("release_rec05", dut_rec(), pk(8'h05, 0, 1, 0, 12'h041));
      step(0, 8'h00, 12'h000, 1, 0);
      check("release_idle", dec_valid, 0);

      // Flush in OP2: presented byte dropped, next byte is a fresh opcode
      step(1, 8'hA7, 12'h050, 1, 0);
      step(1, 8'h00, 12'h051, 1, 0);
      check("flush_partial_valid", dec_valid, 0);
      step(1, 8'h55, 12'h052, 1, 1);
      step(1, 8'h03, 12'h060, 1, 0);
      check("flush_no_record", dec_valid, 0);
      step(0, 8'h00, 12'h000, 1, 0);
      check("flush_next_valid", dec_valid, 1);
      check("flush_next_rec", dut_rec(), pk(8'h03, 0, 1, 0, 12'h060));

      // Flush while a record is stalled
      step(1, 8'h04, 12'h070, 0, 0);
      step(1, 8'h05, 12'h071, 0, 1);
      check("flush_stall_pre", dec_valid, 1);
      step(0, 8'h00, 12'h000, 0, 0);
      check("flush_stall_post", dec_valid, 0);

      // Flush with simultaneous record transfer and accepted-looking byte
      step(1, 8'h60, 12'h080, 1, 0);
      step(1, 8'h1A, 12'h081, 1, 1);
      check("flush_xfer_in_ready", in_ready, 1);
      step(0, 8'h00, 12'h000, 1, 0);
      check("flush_xfer_dropped", dec_valid, 0);

      // Reset in OP1
      step(1, 8'h60, 12'h090, 1, 0);
      step(1, 8'h10, 12'h091, 1, 0);
      check("rst_pre_rec", {dec_valid, dut_rec()}, {1'b1, pk(8'h60, 0, 1, 0, 12'h090)});
      step(1, 8'h7F, 12'h092, 1, 0, 1'b1);
      step(1, 8'h03, 12'h0A0, 1, 0);
      check("rst_mid_outputs", {dec_valid, dut_rec()}, 65'd0);
      check("rst_mid_in_ready", in_ready, 1);
      step(0, 8'h00, 12'h000, 1, 0);
      check("rst_mid_next", {dec_valid, dut_rec()}, {1'b1, pk(8'h03, 0, 1, 0, 12'h0A0)});

      // Randomized traffic against the model
      hold = 1'b0; prev_stall = 1'b0; prev_rec = '0; rpc = 12'h100;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (!hold) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_byte  = pick();
            in_pc    = rpc;
         end
         dec_ready = (c >= 3990) ? 1'b1 : ($urandom_range(0, 9) < 6);
         if (c >= 3990) in_valid = hold;
         flush = 1'b0;
         rst   = 1'b0;
         #1;
         if (prev_stall)
            check("rand_stall_hold", {dec_valid, dut_rec()}, {1'b1, prev_rec});
         check("rand_in_ready", in_ready, !dec_valid || dec_ready);
         if (dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL rand_unexpected_rec: got %h, expected no record", dut_rec());
            end else
               check("rand_rec", dut_rec(), exp_q.pop_front());
         end
         if (in_valid && in_ready) begin
            model_push(in_byte, in_pc);
            rpc = rpc + 12'd1;
         end
         hold       = in_valid && !in_ready;
         prev_stall = dec_valid && !dec_ready;
         prev_rec   = dut_rec();
      end
      check("rand_drained", 64'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bytecode_decode.md
# bytecode_decode

Bytecode decode stage that sits directly downstream of `fetch`. It consumes the fetch byte stream (`instr`, `pc`, `valid`) one byte per cycle and gathers the operand bytes of multi-byte JVM bytecodes. It then emits one fully assembled instruction record per bytecode to the execute stage over a valid/ready handshake. It also supports a flush from execute for taken branches.

## Interface

Parameters:
- `PC_W`, default 12: program-counter width; matches fetch `pc`.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `in_byte`, in, 8: bytecode byte from fetch `instr`.
- `in_pc`, in, PC_W: address of `in_byte`, from fetch `pc`.
- `in_valid`, in, 1: byte present, from fetch `valid`.
- `in_ready`, out, 1: byte accepted this cycle. Fetch holds `instr`/`pc` while `in_valid && !in_ready`.
- `flush`, in, 1: execute redirect; discards all partial and pending state.
- `dec_valid`, out, 1: decoded record present.
- `dec_ready`, in, 1: execute accepts the record.
- `dec_opcode`, out, 8: opcode byte.
- `dec_operand`, out, 16: assembled operand (rules below).
- `dec_pc`, out, PC_W: pc of the opcode byte.
- `dec_len`, out, 2: total instruction length in bytes (1..3).
- `dec_illegal`, out, 1: opcode not in the supported set.

## Operation

- A byte transfers when `in_valid && in_ready`. The record transfers when `dec_valid && dec_ready`.
- `in_ready = !dec_valid || dec_ready`. Operand bytes are gated the same way, so the rule has no state-dependent exceptions.
- States:
  - OPC: expect opcode.
  - OP1: expect the 1st operand byte.
  - OP2: expect the 2nd operand byte.
- Transitions:
  - OPC on accept: look up the length. Length 1 loads the output register and stays in OPC. Length 2 or 3 latches opcode and pc, then goes to OP1.
  - OP1 on accept: length 2 loads the output and goes to OPC. Length 3 latches b1 and goes to OP2.
  - OP2 on accept: loads the output and goes to OPC.
- Length table:
  - Length 2: `bipush` 0x10, `iload` 0x15, `istore` 0x36.
  - Length 3: `sipush` 0x11, `iinc` 0x84, `if<cond>` 0x99–0x9E, `if_icmp<cond>` 0x9F–0xA4, `goto` 0xA7.
  - Length 1: `nop` 0x00, `iconst_m1..5` 0x02–0x08, `iload_0..3` 0x1A–0x1D, `istore_0..3` 0x3B–0x3E, `pop` 0x57, `dup` 0x59, `iadd` 0x60, `isub` 0x64, `imul` 0x68, `ireturn` 0xAC, `return` 0xB1.
  - Any other opcode: length 1 with `dec_illegal=1`.
- Operand assembly:
  - Length 1: `dec_operand = 0`.
  - `bipush`: b1 sign-extended to 16 bits.
  - `iload`/`istore`: `{8'h00, b1}`.
  - Length 3: `{b1, b2}` big-endian. Branch offsets stay raw signed 16-bit, relative to `dec_pc`.
- The `in_pc` of operand bytes is ignored. `dec_pc` is always the opcode byte's pc.
- Flush:
  - Takes effect in the cycle `flush` is high.
  - Next state is OPC and `dec_valid` becomes 0.
  - Any byte presented in the same cycle is dropped, even if `in_ready` was high.
  - Flush overrides a simultaneous record transfer; that record counts as consumed.
- Reset: state OPC. `dec_valid`, `dec_opcode`, `dec_operand`, `dec_pc`, `dec_len` and `dec_illegal` are all 0. `in_ready` is 1 out of reset.

## Timing

- Latency: `dec_valid` rises the cycle after the final byte of an instruction is accepted.
- Throughput: one byte per cycle while `dec_ready` is held high. A 3-byte instruction therefore produces one record per 3 cycles.
- Output registers hold stable while `dec_valid && !dec_ready`. `in_ready` stays 0 throughout that stall.
- Back-to-back: if the final byte arrives in the same cycle the current record is accepted, the new record replaces it with no bubble.
- Priority: `rst` over `flush`, and `flush` over everything else.

## Structure

- Shared package `jvm_pkg` holds:
  - opcode localparams (`OP_BIPUSH`, `OP_SIPUSH`, `OP_GOTO`, …);
  - the state encoding (`ST_OPC`, `ST_OP1`, `ST_OP2`);
  - the `PC_W` default.
- Sub-module `bytecode_len`: purely combinational. Maps `opcode` to `len[1:0]` and `illegal`. It is reused later by the branch-target unit.
- The FSM, operand latches and output register stay in `bytecode_decode`.

## Test plan

- Stream `10 FE 60`, `dec_ready=1`:
  - record {op 10, operand FFFE, len 2, pc 0};
  - then record {op 60, operand 0000, len 1, pc 2}.
- Stream `11 12 34 A7 FF FC`:
  - record {11, 1234, len 3, pc 0};
  - then record {A7, FFFC, len 3, pc 3}.
- Hold `dec_ready=0` for 4 cycles after `04` is decoded:
  - `in_ready=0`;
  - fetch byte `05` is held, not lost;
  - outputs stay stable;
  - releasing gives record 04 followed by record 05.
- Assert `flush` after `A7 00` (in OP2):
  - `dec_valid` stays 0;
  - next byte `03` decodes as op 03, len 1, with its own pc.
- Feed opcode `CA` → record with `dec_illegal=1`, len 1, state back in OPC.
- Assert `rst` mid-instruction (in OP1) → next cycle all outputs are 0 and `in_ready=1`.
